// File: rtl/salamander_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | salamander_pkg: shared types and constants for the Salamander-4 core  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package salamander_pkg;

  localparam int INSTR_W = 6;

  // Instruction word fields: [5] ACC_CE, [4:2] OP_CODE, [1:0] ADDR
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int OP_LSB   = 2;
  localparam int OP_MSB   = 4;
  localparam int ACC_BIT  = 5;

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_ST  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam logic [INSTR_W-1:0] HALT_WORD = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } ifetch_state_t;

  function automatic logic [2:0] instr_op(input logic [INSTR_W-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_pc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ifetch_pc: program counter with reset load, increment and jump load  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module ifetch_pc #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  output logic [PC_W-1:0] pc
);

  // Increment wraps naturally modulo 2^PC_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= jmp_en ? jmp_addr : pc + PC_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | instr_fetch: Salamander-4 fetch/issue unit (ROM REQ/ACK -> decoder)   |
// | Optional single-step support when IFETCH_STEP_EN is defined.          |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module instr_fetch
  import salamander_pkg::*;
#(
  parameter int                 PC_W       = 8,
  parameter logic [PC_W-1:0]    RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               stall,
  input  logic               jmp_en,
  input  logic [PC_W-1:0]    jmp_addr,
`ifdef IFETCH_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic               rom_req,
  output logic [PC_W-1:0]    rom_addr,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic               id_ce,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  ifetch_state_t state, state_n;
  logic          load;
  logic          advance;
  logic          start;
  logic          refetch;

`ifdef IFETCH_STEP_EN
  assign start   = step_mode ? step : run;
  assign refetch = run & ~step_mode;
`else
  assign start   = run;
  assign refetch = run;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      instr <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        instr <= rom_data;
      end
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = FETCH;
      end
      FETCH: begin
        // The halt word is swallowed here and never reaches the decoder.
        if (rom_ack) begin
          if (rom_data == HALT_INSTR) begin
            state_n = HALT;
          end else begin
            load    = 1'b1;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!stall) begin
          advance = 1'b1;
          state_n = refetch ? FETCH : IDLE;
        end
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  ifetch_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .jmp_en   (jmp_en),
    .jmp_addr (jmp_addr),
    .pc       (pc)
  );

  assign rom_req  = (state == FETCH);
  assign rom_addr = pc;
  assign id_ce    = advance;
  assign halted   = (state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_instr_fetch: vector table, directed sequences and random traffic  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst, run, stall, jmp_en, rom_ack;
  logic [7:0] jmp_addr;
  logic [5:0] rom_data;
  logic       rom_req, id_ce, halted;
  logic [7:0] rom_addr, pc;
  logic [5:0] instr;
`ifdef IFETCH_STEP_EN
  logic       step_mode, step, pulse_step;
`endif

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .stall    (stall),
    .jmp_en   (jmp_en),
    .jmp_addr (jmp_addr),
`ifdef IFETCH_STEP_EN
    .step_mode(step_mode),
    .step     (step),
`endif
    .rom_req  (rom_req),
    .rom_addr (rom_addr),
    .rom_ack  (rom_ack),
    .rom_data (rom_data),
    .instr    (instr),
    .id_ce    (id_ce),
    .pc       (pc),
    .halted   (halted)
  );

  logic [5:0] rom [256];
  int checks = 0;
  int errors = 0;

  // Transaction-level reference: expected PC, last loaded word, and whether
  // a fetched word is waiting to be issued.
  logic [7:0] m_pc;
  logic [5:0] m_instr;
  logic       m_pending, m_halt;
  int         req_cnt, issues;

  typedef struct {
    logic       run, stall, je;
    logic [7:0] ja;
    logic       ack;
    logic       req;
    logic [7:0] addr;
    logic       idce;
    logic [5:0] instr;
    logic [7:0] pc;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic v(input logic r, s, je, input logic [7:0] ja, input logic ack,
                   input logic req, input logic [7:0] addr, input logic idce,
                   input logic [5:0] ins, input logic [7:0] p);
    vec_t e;
    e.run = r; e.stall = s; e.je = je; e.ja = ja; e.ack = ack;
    e.req = req; e.addr = addr; e.idce = idce; e.instr = ins; e.pc = p;
    vq.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b0; stall = 1'b0; jmp_en = 1'b0; rom_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", rom_req, 0);
    chk("rst_idce", id_ce, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", instr, 0);
    m_pc = 8'h00; m_instr = 6'h00; m_pending = 1'b0; m_halt = 1'b0; req_cnt = 0;
  endtask

  // One clock of scoreboard-checked traffic; the ROM acks after dly REQ cycles.
  task automatic sb_cycle(input logic r, input logic s, input logic je,
                          input logic [7:0] ja, input int dly);
    logic took;
    @(posedge clk); #1;
    run = r; stall = s; jmp_en = je; jmp_addr = ja;
`ifdef IFETCH_STEP_EN
    step = pulse_step; pulse_step = 1'b0;
`endif
    took = 1'b0;
    if (rom_req) begin
      if (req_cnt >= dly) begin
        rom_ack = 1'b1; rom_data = rom[rom_addr]; req_cnt = 0; took = 1'b1;
      end else begin
        rom_ack = 1'b0; rom_data = 6'($urandom); req_cnt++;
      end
    end else begin
      rom_ack = 1'($urandom); rom_data = 6'($urandom); req_cnt = 0;
    end
    @(negedge clk);
    chk("halted", halted, m_halt);
    chk("pc", pc, m_pc);
    chk("instr", instr, m_instr);
    chk("idce", id_ce, m_pending && !s);
    if (m_halt) chk("req_halt", rom_req, 0);
    if (rom_req) begin
      chk("addr", rom_addr, m_pc);
      chk("req_while_pending", m_pending, 0);
    end
    if (id_ce) begin
      issues++;
      m_pending = 1'b0;
      m_pc = je ? ja : m_pc + 8'd1;
    end
    if (took) begin
      if (rom_data == 6'h3F) m_halt = 1'b1;
      else begin m_pending = 1'b1; m_instr = rom_data; end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; stall = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h00;
    rom_ack = 1'b0; rom_data = 6'h00; issues = 0;
`ifdef IFETCH_STEP_EN
    step_mode = 1'b0; step = 1'b0; pulse_step = 1'b0;
`endif
    for (int i = 0; i < 256; i++) rom[i] = 6'h00;
    rom[8'h00] = 6'h05; rom[8'h01] = 6'h12; rom[8'h02] = 6'h23;
    rom[8'h40] = 6'h2A; rom[8'h41] = 6'h01; rom[8'h42] = 6'h10; rom[8'hFF] = 6'h1B;

    //  run st je ja     ack | req addr   ce ins    pc
    v(1, 0, 0, 8'h00, 0,  0, 8'h00, 0, 6'h00, 8'h00);
    v(1, 0, 0, 8'h00, 1,  1, 8'h00, 0, 6'h00, 8'h00);
    v(1, 0, 0, 8'h00, 0,  0, 8'h00, 1, 6'h05, 8'h00);
    v(1, 0, 0, 8'h00, 1,  1, 8'h01, 0, 6'h05, 8'h01);
    v(1, 0, 0, 8'h00, 0,  0, 8'h01, 1, 6'h12, 8'h01);
    v(1, 0, 0, 8'h00, 1,  1, 8'h02, 0, 6'h12, 8'h02);
    v(1, 0, 1, 8'h01, 0,  0, 8'h02, 1, 6'h23, 8'h02);
    for (int i = 0; i < 3; i++) v(1, 0, 0, 8'h00, 0, 1, 8'h01, 0, 6'h23, 8'h01);
    v(1, 0, 0, 8'h00, 1,  1, 8'h01, 0, 6'h23, 8'h01);
    for (int i = 0; i < 5; i++) v(1, 1, 1, 8'h77, 0, 0, 8'h01, 0, 6'h12, 8'h01);
    v(1, 0, 1, 8'h40, 0,  0, 8'h01, 1, 6'h12, 8'h01);
    v(1, 0, 0, 8'h00, 1,  1, 8'h40, 0, 6'h12, 8'h40);
    v(0, 0, 0, 8'h00, 0,  0, 8'h40, 1, 6'h2A, 8'h40);
    v(0, 0, 0, 8'h00, 0,  0, 8'h41, 0, 6'h2A, 8'h41);
    v(1, 0, 0, 8'h00, 0,  0, 8'h41, 0, 6'h2A, 8'h41);
    v(0, 0, 0, 8'h00, 1,  1, 8'h41, 0, 6'h2A, 8'h41);
    v(0, 0, 0, 8'h00, 0,  0, 8'h41, 1, 6'h01, 8'h41);
    v(1, 0, 0, 8'h00, 0,  0, 8'h42, 0, 6'h01, 8'h42);
    v(1, 0, 0, 8'h00, 1,  1, 8'h42, 0, 6'h01, 8'h42);
    v(1, 0, 1, 8'hFF, 0,  0, 8'h42, 1, 6'h10, 8'h42);
    v(1, 0, 0, 8'h00, 1,  1, 8'hFF, 0, 6'h10, 8'hFF);
    v(1, 0, 0, 8'h00, 0,  0, 8'hFF, 1, 6'h1B, 8'hFF);
    v(1, 0, 0, 8'h00, 0,  1, 8'h00, 0, 6'h1B, 8'h00);

    do_reset();
    foreach (vq[i]) begin
      @(posedge clk); #1;
      run = vq[i].run; stall = vq[i].stall; jmp_en = vq[i].je; jmp_addr = vq[i].ja;
      rom_ack = vq[i].ack; rom_data = rom[rom_addr];
      @(negedge clk);
      chk($sformatf("row%0d_req", i), rom_req, vq[i].req);
      chk($sformatf("row%0d_addr", i), rom_addr, vq[i].addr);
      chk($sformatf("row%0d_idce", i), id_ce, vq[i].idce);
      chk($sformatf("row%0d_instr", i), instr, vq[i].instr);
      chk($sformatf("row%0d_pc", i), pc, vq[i].pc);
      chk($sformatf("row%0d_halted", i), halted, 0);
    end
    // The last row leaves a handshake open: reset must abort it.
    do_reset();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 256; i++) rom[i] = 6'($urandom_range(0, 62));
    do_reset();
    issues = 0;
    for (int c = 0; c < 600; c++)
      sb_cycle(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
               8'($urandom), int'($urandom % 4));
    chk("random_progress", issues >= 20, 1);

    // Halt word at address 4: four issues, then permanently halted.
    rom[0] = 6'h05; rom[1] = 6'h12; rom[2] = 6'h23; rom[3] = 6'h0C; rom[4] = 6'h3F;
    do_reset();
    issues = 0;
    for (int c = 0; c < 40; c++) sb_cycle(1'b1, 1'b0, 1'b0, 8'h00, c % 2);
    chk("halt_final", halted, 1);
    chk("halt_issues", issues, 4);
    chk("halt_pc", pc, 4);
    do_reset();

`ifdef IFETCH_STEP_EN
    for (int i = 0; i < 256; i++) rom[i] = 6'($urandom_range(0, 62));
    do_reset();
    step_mode = 1'b1;
    issues = 0;
    for (int p = 0; p < 3; p++) begin
      pulse_step = 1'b1;
      for (int c = 0; c < 12; c++)
        sb_cycle(1'($urandom), 1'b0, 1'b0, 8'h00, int'($urandom % 4));
    end
    chk("step_issues", issues, 3);
    chk("step_idle_req", rom_req, 0);
    step_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
